// File: rtl/pulse_stretcher.sv
// Per-channel LED pulse stretcher: ON window, forced OFF gap, one-deep event queue, sticky drop flag.
// Optional PULSE_STRETCHER_RETRIGGER_EN: a pulse during ON extends the window instead of queueing.

module pulse_stretcher_lane #(
  parameter int ON_CYCLES  = 4,
  parameter int OFF_CYCLES = 2,
  parameter int CNT_W      = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic pulse,
  output logic led,
  output logic busy,
  output logic dropped
);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_GAP} state_t;

  localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(OFF_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             drop_q, drop_d;
  logic             led_q, busy_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      drop_q  <= 1'b0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
      led_q   <= (state_d == S_ON);
      busy_q  <= (state_d != S_IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    drop_d  = drop_q;
    case (state_q)
      S_IDLE: begin
        if (pulse) begin
          state_d = S_ON;
          cnt_d   = ON_LOAD;
        end
      end
      S_ON: begin
`ifdef PULSE_STRETCHER_RETRIGGER_EN
        if (pulse) begin
          cnt_d = ON_LOAD;
        end else if (cnt_q == '0) begin
          state_d = S_GAP;
          cnt_d   = OFF_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
`else
        if (cnt_q == '0) begin
          state_d = S_GAP;
          cnt_d   = OFF_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
        if (pulse) begin
          if (pend_q) drop_d = 1'b1;
          else        pend_d = 1'b1;
        end
`endif
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          // Queued event is consumed; a fresh pulse on the same edge re-queues behind it.
          if (pend_q || pulse) begin
            state_d = S_ON;
            cnt_d   = ON_LOAD;
            pend_d  = pend_q & pulse;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (pulse) begin
            if (pend_q) drop_d = 1'b1;
            else        pend_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        pend_d  = 1'b0;
      end
    endcase
  end

  assign led     = led_q;
  assign busy    = busy_q;
  assign dropped = drop_q;

endmodule

module pulse_stretcher #(
  parameter int NCH        = 5,
  parameter int ON_CYCLES  = 4,
  parameter int OFF_CYCLES = 2,
  parameter int CNT_W      = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NCH-1:0] pulse_in,
  output logic [NCH-1:0] led,
  output logic [NCH-1:0] busy,
  output logic [NCH-1:0] dropped
);

  for (genvar g = 0; g < NCH; g++) begin : g_lane
    pulse_stretcher_lane #(
      .ON_CYCLES (ON_CYCLES),
      .OFF_CYCLES(OFF_CYCLES),
      .CNT_W     (CNT_W)
    ) u_lane (
      .clk    (clk),
      .reset  (reset),
      .pulse  (pulse_in[g]),
      .led    (led[g]),
      .busy   (busy[g]),
      .dropped(dropped[g])
    );
  end

endmodule
